// File: rtl/obc_dft_pkg.sv
// Shared types and helpers for the OBC DFT bin datapath.
// Words are Q10.21; bin sums carry three extra integer bits.
package obc_dft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ACC_W_DEF  = 32;
   localparam int Q_INT_W    = 10;
   localparam int Q_FRAC_W   = 21;
   localparam int SUM_GROWTH = 3;

   // Sign-extends the low w bits of v to 64 bits; callers truncate to their width.
   function automatic logic signed [63:0] sext64(input logic [63:0] v, input int w);
      logic signed [63:0] t;
      t = $signed(v << (64 - w));
      return t >>> (64 - w);
   endfunction

endpackage

// File: rtl/obc_rom_sum8.sv
// Combinational sign-extending adder tree over the eight ROM words of one bin.
// Output is wide enough that eight full-scale words cannot overflow.
module obc_rom_sum8
   import obc_dft_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [8*ACC_W-1:0]          words,
   output logic [ACC_W+SUM_GROWTH-1:0] sum
);

   localparam int SUM_W = ACC_W + SUM_GROWTH;

   logic [SUM_W-1:0] ext [8];
   logic [SUM_W-1:0] lvl1 [4];
   logic [SUM_W-1:0] lvl2 [2];

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         ext[k] = SUM_W'(sext64(64'(words[k*ACC_W +: ACC_W]), ACC_W));
      end
      for (int k = 0; k < 4; k++) begin
         lvl1[k] = ext[2*k] + ext[2*k+1];
      end
      lvl2[0] = lvl1[0] + lvl1[1];
      lvl2[1] = lvl1[2] + lvl1[3];
      sum     = lvl2[0] + lvl2[1];
   end

endmodule

// File: rtl/obc_dft_bin_sequencer.sv
// Bit-serial OBC controller for one 16-point DFT bin: slices samples LSB first,
// shift-accumulates the ROM sum, subtracts the sign-bit term and adds the offset.
module obc_dft_bin_sequencer
   import obc_dft_pkg::*;
#(
   parameter int                      DATA_W   = 16,
   parameter int                      ACC_W    = ACC_W_DEF,
   parameter logic signed [ACC_W-1:0] OFFSET_K = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [16*DATA_W-1:0]          x_flat,
   output logic [15:0]                   bit_slice,
   input  logic [ACC_W-1:0]              rom_out0,
   input  logic [ACC_W-1:0]              rom_out1,
   input  logic [ACC_W-1:0]              rom_out2,
   input  logic [ACC_W-1:0]              rom_out3,
   input  logic [ACC_W-1:0]              rom_out4,
   input  logic [ACC_W-1:0]              rom_out5,
   input  logic [ACC_W-1:0]              rom_out6,
   input  logic [ACC_W-1:0]              rom_out7,
   output logic                          busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_W+SUM_GROWTH-1:0]   dout
);

   localparam int SUM_W = ACC_W + SUM_GROWTH;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t                   state, state_nxt;
   logic [DATA_W-1:0]        smp [16];
   logic [CNT_W-1:0]         b;
   logic signed [SUM_W-1:0]  acc;
   logic signed [SUM_W-1:0]  dout_r;
   logic [SUM_W-1:0]         s_sum;
   logic signed [SUM_W-1:0]  s_b;
   logic signed [SUM_W-1:0]  offset_ext;
   logic                     last_bit;

   // Wrapping add followed by arithmetic halving; no saturation by design.
   function automatic logic signed [SUM_W-1:0] acc_step(input logic signed [SUM_W-1:0] a,
                                                       input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] t;
      t = a + s;
      return t >>> 1;
   endfunction

   obc_rom_sum8 #(.ACC_W(ACC_W)) u_sum8 (
      .words ({rom_out7, rom_out6, rom_out5, rom_out4,
               rom_out3, rom_out2, rom_out1, rom_out0}),
      .sum   (s_sum)
   );

   assign s_b        = $signed(s_sum);
   assign offset_ext = SUM_W'(sext64(64'(OFFSET_K), ACC_W));
   assign last_bit   = (b == CNT_W'(DATA_W - 1));
   assign dout       = dout_r;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      bit_slice = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            for (int n = 0; n < 16; n++) bit_slice[n] = smp[n][0];
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The sign-bit slice arrives last and carries negative weight, hence the subtract.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b      <= '0;
         acc    <= '0;
         dout_r <= '0;
         for (int n = 0; n < 16; n++) smp[n] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int n = 0; n < 16; n++) smp[n] <= x_flat[n*DATA_W +: DATA_W];
                  acc <= '0;
                  b   <= '0;
               end
            end
            RUN: begin
               for (int n = 0; n < 16; n++) smp[n] <= smp[n] >> 1;
               if (last_bit) begin
                  dout_r <= acc - s_b + offset_ext;
               end else begin
                  acc <= acc_step(acc, s_b);
                  b   <= b + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_obc_dft_bin_sequencer.sv
// Randomized bench for obc_dft_bin_sequencer against an integer reference of the
// bin sum (signed coefficients per sample bit, shift-add, negated sign bit, offset).
module tb_obc_dft_bin_sequencer;

   localparam int     MODE_BIN13 = 0;
   localparam int     MODE_MIN   = 1;
   localparam longint OFF16      = -5000000;

   typedef logic [15:0] frame_t [16];

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic         iv16, ir16, busy16, ov16, or16;
   logic [255:0] x16;
   logic [15:0]  bs16;
   logic [31:0]  rw16 [8];
   logic [34:0]  dout16;

   logic         iv4, ir4, busy4, ov4, or4;
   logic [63:0]  x4;
   logic [15:0]  bs4;
   logic [34:0]  dout4;

   int     coef [16];
   int     mode;
   int     vectors = 0;
   int     miscompares = 0;
   longint expq [$];

   always #5 clk = ~clk;

   obc_dft_bin_sequencer #(.DATA_W(16), .ACC_W(32), .OFFSET_K(-32'sd5000000)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .x_flat(x16),
      .bit_slice(bs16),
      .rom_out0(rw16[0]), .rom_out1(rw16[1]), .rom_out2(rw16[2]), .rom_out3(rw16[3]),
      .rom_out4(rw16[4]), .rom_out5(rw16[5]), .rom_out6(rw16[6]), .rom_out7(rw16[7]),
      .busy(busy16), .out_valid(ov16), .out_ready(or16), .dout(dout16)
   );

   obc_dft_bin_sequencer #(.DATA_W(4), .ACC_W(32), .OFFSET_K(32'sd0)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .x_flat(x4),
      .bit_slice(bs4),
      .rom_out0(32'd1), .rom_out1(32'd1), .rom_out2(32'd1), .rom_out3(32'd1),
      .rom_out4(32'd1), .rom_out5(32'd1), .rom_out6(32'd1), .rom_out7(32'd1),
      .busy(busy4), .out_valid(ov4), .out_ready(or4), .dout(dout4)
   );

   // Pairwise ROM bank: each word holds the signed coefficients of two samples.
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         if (mode == MODE_MIN) rw16[j] = 32'h8000_0000;
         else rw16[j] = 32'((bs16[2*j]   ? coef[2*j]   : -coef[2*j]) +
                            (bs16[2*j+1] ? coef[2*j+1] : -coef[2*j+1]));
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sd35(input logic [34:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint wrap35(input longint v);
      longint r;
      r = v & 64'h7_FFFF_FFFF;
      if (r[34]) r = r - (64'sd1 <<< 35);
      return r;
   endfunction

   function automatic longint rom_sum(input logic [15:0] sl, input int m);
      longint s = 0;
      if (m == MODE_MIN) return -(64'sd1 <<< 34);
      for (int n = 0; n < 16; n++) s += sl[n] ? longint'(coef[n]) : -longint'(coef[n]);
      return s;
   endfunction

   function automatic longint model(input frame_t f, input int m, input longint off);
      longint      acc = 0;
      longint      s;
      logic [15:0] sl;
      for (int b = 0; b < 16; b++) begin
         for (int n = 0; n < 16; n++) sl[n] = f[n][b];
         s = rom_sum(sl, m);
         if (b < 15) acc = wrap35(acc + s) >>> 1;
         else return wrap35(acc - s + off);
      end
      return 0;
   endfunction

   function automatic logic [255:0] pack16(input frame_t f);
      logic [255:0] v;
      for (int n = 0; n < 16; n++) v[n*16 +: 16] = f[n];
      return v;
   endfunction

   task automatic rand_frame(output frame_t f);
      for (int n = 0; n < 16; n++) f[n] = 16'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t      fr, fr2;
      longint      held, exp_v;
      logic [15:0] eb;

      for (int n = 0; n < 16; n++)
         coef[n] = $rtoi(-$sin(2.0 * 3.14159265358979 * 13.0 * n / 16.0) * 1048576.0);
      mode = MODE_BIN13;
      iv16 = 0; or16 = 0; x16 = '0;
      iv4  = 0; or4  = 0; x4  = '0;
      rst_n = 0;
      repeat (3) tick();

      chk("rst_in_ready16", ir16, 1);  chk("rst_busy16", busy16, 0);
      chk("rst_out_valid16", ov16, 0); chk("rst_dout16", sd35(dout16), 0);
      chk("rst_bit_slice16", bs16, 0);
      chk("rst_in_ready4", ir4, 1);    chk("rst_out_valid4", ov4, 0);
      chk("rst_dout4", sd35(dout4), 0);
      rst_n = 1;
      tick();

      // Constant ROM sum of 8 on a 4-bit instance: acc 4, 6, 7, then 7-8.
      x4 = {$urandom, $urandom};
      iv4 = 1;
      tick();
      iv4 = 0;
      chk("d4_busy", busy4, 1);
      chk("d4_in_ready_run", ir4, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("d4_out_valid_early%0d", k), ov4, 0);
         tick();
      end
      chk("d4_out_valid", ov4, 1);
      chk("d4_dout", sd35(dout4), -1);
      chk("d4_bit_slice_done", bs4, 0);
      or4 = 1;
      tick();
      or4 = 0;
      chk("d4_out_valid_after", ov4, 0);
      chk("d4_in_ready_after", ir4, 1);

      // Ramp x[n] = n*1024 through the bin-13 imaginary ROM.
      for (int n = 0; n < 16; n++) fr[n] = 16'(n * 1024);
      x16 = pack16(fr);
      iv16 = 1;
      tick();
      iv16 = 0;
      for (int b = 0; b < 16; b++) begin
         for (int n = 0; n < 16; n++) eb[n] = fr[n][b];
         chk($sformatf("ramp_bit_slice_b%0d", b), bs16, eb);
         if (b == 10) chk("ramp_bit_slice_b10_const", bs16, 16'hAAAA);
         tick();
      end
      chk("ramp_out_valid", ov16, 1);
      chk("ramp_dout", sd35(dout16), model(fr, MODE_BIN13, OFF16));
      chk("ramp_bit_slice_done", bs16, 0);

      // Backpressure with a second frame pending on the input.
      held = sd35(dout16);
      rand_frame(fr2);
      x16 = pack16(fr2);
      iv16 = 1;
      or16 = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("bp_dout_hold", sd35(dout16), held);
         chk("bp_in_ready", ir16, 0);
         chk("bp_out_valid", ov16, 1);
      end
      or16 = 1;
      tick();
      or16 = 0;
      chk("bp_release_out_valid", ov16, 0);
      chk("bp_release_in_ready", ir16, 1);
      tick();
      iv16 = 0;
      chk("bp_accept_busy", busy16, 1);
      repeat (16) tick();
      chk("bp_second_valid", ov16, 1);
      chk("bp_second_dout", sd35(dout16), model(fr2, MODE_BIN13, OFF16));
      or16 = 1;
      tick();
      or16 = 0;

      // Reset asserted at b=2 of a run.
      rand_frame(fr);
      x16 = pack16(fr);
      iv16 = 1;
      tick();
      iv16 = 0;
      tick();
      tick();
      chk("midrst_busy_before", busy16, 1);
      rst_n = 0;
      tick();
      chk("midrst_in_ready", ir16, 1);  chk("midrst_out_valid", ov16, 0);
      chk("midrst_busy", busy16, 0);    chk("midrst_dout", sd35(dout16), 0);
      chk("midrst_bit_slice", bs16, 0);
      rst_n = 1;
      tick();

      // Most-negative samples and ROM words: accumulator wraps.
      mode = MODE_MIN;
      for (int n = 0; n < 16; n++) fr[n] = 16'h8000;
      x16 = pack16(fr);
      iv16 = 1;
      tick();
      iv16 = 0;
      repeat (16) tick();
      chk("min_out_valid", ov16, 1);
      chk("min_dout_known", longint'($isunknown(dout16)), 0);
      chk("min_dout", sd35(dout16), model(fr, MODE_MIN, OFF16));
      or16 = 1;
      tick();
      or16 = 0;
      mode = MODE_BIN13;

      // Streaming 100 random frames with random downstream readiness.
      fork
         begin : producer
            frame_t pf;
            int     k;
            for (int i = 0; i < 100; i++) begin
               rand_frame(pf);
               x16 = pack16(pf);
               iv16 = 1;
               k = 0;
               while (!ir16 && k < 200) begin
                  tick();
                  k++;
               end
               if (!ir16) begin
                  chk("stream_accept_timeout", 0, 1);
                  break;
               end
               expq.push_back(model(pf, MODE_BIN13, OFF16));
               tick();
               iv16 = 0;
               if ($urandom_range(3) == 0) tick();
            end
            iv16 = 0;
         end
         begin : consumer
            int  got = 0;
            int  cyc = 0;
            bit  r;
            while (got < 100 && cyc < 20000) begin
               r = 1'($urandom_range(1));
               or16 = r;
               if (ov16 && r) begin
                  if (expq.size() == 0) chk("stream_unexpected_result", sd35(dout16), 0);
                  else begin
                     exp_v = expq.pop_front();
                     chk($sformatf("stream_dout%0d", got), sd35(dout16), exp_v);
                  end
                  got++;
               end
               tick();
               cyc++;
            end
            or16 = 0;
            chk("stream_result_count", got, 100);
         end
      join
      chk("stream_queue_empty", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
